// File: rtl/relu_quant_stream.sv
// relu_quant_stream: captures a conv feature map, applies bias/ReLU/shift requantise, streams uint8 row-major
module relu_quant_stream #(
   parameter int H          = 12,
   parameter int W          = 11,
   parameter int DATA_WIDTH = 24,
   parameter int IDX_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data [H][W],
   input  logic [DATA_WIDTH-1:0] bias,
   input  logic [4:0]            shift,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [7:0]            out_data,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overrun
);
   localparam int N  = H * W;
   localparam int RW = $clog2(H);
   localparam int CW = $clog2(W);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] buf_q [H][W];
   logic [DATA_WIDTH-1:0] bias_q, bias_d;
   logic [4:0]            shift_q, shift_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [IDX_W-1:0]      out_idx_q, out_idx_d;
   logic [7:0]            out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic                  cap;
   logic [4:0]            sh_sat;
   logic                  wrap;
   logic [RW-1:0]         nr;
   logic [CW-1:0]         nc;
   logic [IDX_W-1:0]      nxt;

   // Bias add in one extra bit so it cannot overflow, then ReLU, shift and clamp to uint8
   function automatic logic [7:0] quant(input logic [DATA_WIDTH-1:0] x,
                                        input logic [DATA_WIDTH-1:0] b,
                                        input logic [4:0] sh);
      logic signed [DATA_WIDTH:0] s;
      logic signed [DATA_WIDTH:0] q;
      s = $signed({x[DATA_WIDTH-1], x}) + $signed({b[DATA_WIDTH-1], b});
      q = s >>> sh;
      return (s <= 0) ? 8'd0 : (q > 255) ? 8'd255 : q[7:0];
   endfunction

   assign sh_sat = (shift > 5'd23) ? 5'd23 : shift;
   assign wrap   = (col_q == CW'(W - 1));
   assign nc     = wrap ? '0 : col_q + CW'(1);
   assign nr     = wrap ? row_q + RW'(1) : row_q;
   assign nxt    = out_idx_q + IDX_W'(1);

   // Next-state: capture on in_valid when idle, advance one element per accepted beat
   always_comb begin
      state_d     = state_q;
      bias_d      = bias_q;
      shift_d     = shift_q;
      row_d       = row_q;
      col_d       = col_q;
      out_idx_d   = out_idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      cap         = 1'b0;
      overrun_d   = overrun_q | (state_q == STREAM && in_valid);
      if (state_q == IDLE) begin
         if (in_valid) begin
            cap         = 1'b1;
            state_d     = STREAM;
            bias_d      = bias;
            shift_d     = sh_sat;
            row_d       = '0;
            col_d       = '0;
            out_idx_d   = '0;
            out_data_d  = quant(in_data[0][0], bias, sh_sat);
            out_valid_d = 1'b1;
            out_last_d  = (N == 1);
            busy_d      = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         if (out_last_q) begin
            state_d     = IDLE;
            row_d       = '0;
            col_d       = '0;
            out_idx_d   = '0;
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
         end else begin
            row_d      = nr;
            col_d      = nc;
            out_idx_d  = nxt;
            out_data_d = quant(buf_q[nr][nc], bias_q, shift_q);
            out_last_d = (nxt == LAST);
         end
      end
   end

   // Control and output registers; reset aborts any stream in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bias_q      <= '0;
         shift_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         out_idx_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         bias_q      <= bias_d;
         shift_q     <= shift_d;
         row_q       <= row_d;
         col_q       <= col_d;
         out_idx_q   <= out_idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   // Map buffer has no reset; it is only meaningful after a capture
   always_ff @(posedge clk) begin
      if (cap) buf_q <= in_data;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;
endmodule
